// File: rtl/weight_sequencer_pkg.sv
// Shared types and constants for the systolic-array weight sequencer.
// The optional WEIGHT_SEQ_PERF_EN build uses the counter width and sat_inc helper below.
package weight_sequencer_pkg;

    localparam int EXTENDED_BYTE_WIDTH = 8;
    localparam int PERF_COUNTER_WIDTH  = 16;

    typedef logic [EXTENDED_BYTE_WIDTH-1:0] extended_byte_type;

    typedef logic [1:0] weight_seq_state_type;
    localparam weight_seq_state_type WS_IDLE    = 2'd0;
    localparam weight_seq_state_type WS_PRELOAD = 2'd1;
    localparam weight_seq_state_type WS_READY   = 2'd2;
    localparam weight_seq_state_type WS_SWAP    = 2'd3;

    // Saturating increment so counters stick at all-ones instead of wrapping.
    function automatic logic [PERF_COUNTER_WIDTH-1:0] sat_inc(input logic [PERF_COUNTER_WIDTH-1:0] v);
        logic [PERF_COUNTER_WIDTH-1:0] r;
        if (v == {PERF_COUNTER_WIDTH{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(PERF_COUNTER_WIDTH-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

endpackage

// File: rtl/weight_sequencer.sv
// Weight sequencer: streams one tile of weight rows into the array's shadow registers, then swaps on request.
// Optional macro WEIGHT_SEQ_PERF_EN adds stall and tile performance counters.
module weight_sequencer
    import weight_sequencer_pkg::*;
#(
    parameter int MATRIX_WIDTH  = 8,
    parameter int ROW_CNT_WIDTH = $clog2(MATRIX_WIDTH + 1)
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [ROW_CNT_WIDTH-1:0]                    cmd_rows,
    input  logic                                        w_valid,
    output logic                                        w_ready,
    input  logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] w_data,
    output logic [MATRIX_WIDTH*EXTENDED_BYTE_WIDTH-1:0] weight_out,
    output logic [MATRIX_WIDTH-1:0]                     preload_row_en,
    input  logic                                        swap_req,
    output logic                                        load_weight,
    output logic                                        shadow_full
`ifdef WEIGHT_SEQ_PERF_EN
    ,
    output logic [PERF_COUNTER_WIDTH-1:0]               perf_stall_cycles,
    output logic [PERF_COUNTER_WIDTH-1:0]               perf_tiles
`endif
);

    localparam logic [ROW_CNT_WIDTH-1:0] ROWS_MAX = ROW_CNT_WIDTH'(MATRIX_WIDTH);
    localparam logic [ROW_CNT_WIDTH-1:0] ROW_LAST = ROW_CNT_WIDTH'(MATRIX_WIDTH - 1);
    localparam logic [ROW_CNT_WIDTH-1:0] ROW_ONE  = ROW_CNT_WIDTH'(1);

    weight_seq_state_type         state_q, state_d;
    logic [ROW_CNT_WIDTH-1:0]     row_cnt_q, row_cnt_d;
    logic [ROW_CNT_WIDTH-1:0]     rows_lim_q, rows_lim_d;
    logic                         stream_s;

    function automatic logic [MATRIX_WIDTH-1:0] onehot(input logic [ROW_CNT_WIDTH-1:0] idx);
        logic [MATRIX_WIDTH-1:0] v;
        v = {MATRIX_WIDTH{1'b0}};
        for (int i = 0; i < MATRIX_WIDTH; i++) begin
            if (idx == ROW_CNT_WIDTH'(i)) begin
                v[i] = 1'b1;
            end else begin
                v[i] = 1'b0;
            end
        end
        return v;
    endfunction

    assign stream_s = (row_cnt_q < rows_lim_q);

    // State register and row counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= WS_IDLE;
            row_cnt_q  <= {ROW_CNT_WIDTH{1'b0}};
            rows_lim_q <= {ROW_CNT_WIDTH{1'b0}};
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            rows_lim_q <= rows_lim_d;
        end
    end

    // Next-state and output decode; rows past the command's count are strobed with zero weights.
    always_comb begin
        state_d        = state_q;
        row_cnt_d      = row_cnt_q;
        rows_lim_d     = rows_lim_q;
        cmd_ready      = 1'b0;
        w_ready        = 1'b0;
        weight_out     = {(MATRIX_WIDTH*EXTENDED_BYTE_WIDTH){1'b0}};
        preload_row_en = {MATRIX_WIDTH{1'b0}};
        load_weight    = 1'b0;
        shadow_full    = 1'b0;
        case (state_q)
            WS_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    rows_lim_d = (cmd_rows > ROWS_MAX) ? ROWS_MAX : cmd_rows;
                    row_cnt_d  = {ROW_CNT_WIDTH{1'b0}};
                    state_d    = WS_PRELOAD;
                end else begin
                    state_d = WS_IDLE;
                end
            end
            WS_PRELOAD: begin
                if (stream_s) begin
                    w_ready    = 1'b1;
                    weight_out = w_data;
                    if (w_valid) begin
                        preload_row_en = onehot(row_cnt_q);
                        row_cnt_d      = row_cnt_q + ROW_ONE;
                        state_d        = (row_cnt_q == ROW_LAST) ? WS_READY : WS_PRELOAD;
                    end else begin
                        state_d = WS_PRELOAD;
                    end
                end else begin
                    preload_row_en = onehot(row_cnt_q);
                    row_cnt_d      = row_cnt_q + ROW_ONE;
                    state_d        = (row_cnt_q == ROW_LAST) ? WS_READY : WS_PRELOAD;
                end
            end
            WS_READY: begin
                shadow_full = 1'b1;
                if (swap_req) begin
                    state_d = WS_SWAP;
                end else begin
                    state_d = WS_READY;
                end
            end
            WS_SWAP: begin
                load_weight = 1'b1;
                shadow_full = 1'b1;
                state_d     = WS_IDLE;
            end
            default: begin
                state_d = WS_IDLE;
            end
        endcase
    end

`ifdef WEIGHT_SEQ_PERF_EN
    logic [PERF_COUNTER_WIDTH-1:0] perf_stall_q;
    logic [PERF_COUNTER_WIDTH-1:0] perf_tiles_q;

    // Saturating stall and tile counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_stall_q <= {PERF_COUNTER_WIDTH{1'b0}};
            perf_tiles_q <= {PERF_COUNTER_WIDTH{1'b0}};
        end else begin
            if (state_q == WS_PRELOAD && stream_s && !w_valid) begin
                perf_stall_q <= sat_inc(perf_stall_q);
            end
            if (state_q == WS_SWAP) begin
                perf_tiles_q <= sat_inc(perf_tiles_q);
            end
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_tiles        = perf_tiles_q;
`endif

endmodule

// File: tb/tb_weight_sequencer.sv
// Scoreboard bench for weight_sequencer: expected strobes are queued per command and matched against observed strobes.
module tb_weight_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_rows;
    logic        w_valid;
    logic        w_ready;
    logic [63:0] w_data;
    logic [63:0] weight_out;
    logic [7:0]  preload_row_en;
    logic        swap_req;
    logic        load_weight;
    logic        shadow_full;
`ifdef WEIGHT_SEQ_PERF_EN
    logic [15:0] perf_stall_cycles;
    logic [15:0] perf_tiles;
`endif

    weight_sequencer dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_rows(cmd_rows),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .weight_out(weight_out),
        .preload_row_en(preload_row_en), .swap_req(swap_req), .load_weight(load_weight),
        .shadow_full(shadow_full)
`ifdef WEIGHT_SEQ_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_tiles(perf_tiles)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int viol  = 0;
    int load_cnt = 0;

    logic [71:0] exp_q[$];
    logic [71:0] obs_q[$];
    logic [71:0] e, o;

    logic [7:0]  obs_row_en;
    logic [63:0] obs_wout;
    logic        obs_wready, obs_load, obs_full, obs_cmd_ready;

    int ncyc, consumed, wready_cnt, cmdrdy_cnt;
    logic saw_full;

    // Background monitor: multi-hot strobes, strobe/load overlap, and load pulse count.
    always @(negedge clk) begin
        if ($countones(preload_row_en) > 1 || (load_weight && preload_row_en != 8'h00)) viol++;
        if (load_weight) load_cnt++;
    end

    function automatic void push_exp(input logic [3:0] rows);
        int lim;
        logic [7:0] one;
        logic [7:0] b;
        lim = (rows > 4'd8) ? 8 : int'(rows);
        one = 8'h01;
        for (int k = 0; k < 8; k++) begin
            b = 8'(k + 1);
            exp_q.push_back({one << k, (k < lim) ? {8{b}} : 64'h0});
        end
    endfunction

    // Called at posedge+1: drive inputs, sample at negedge, return at next posedge+1.
    task automatic tick(input logic v, input logic [63:0] d, input logic sw);
        w_valid = v; w_data = d; swap_req = sw;
        @(negedge clk);
        obs_row_en = preload_row_en; obs_wout = weight_out; obs_wready = w_ready;
        obs_load = load_weight; obs_full = shadow_full; obs_cmd_ready = cmd_ready;
        @(posedge clk); #1;
    endtask

    task automatic send_cmd(input logic [3:0] rows, input logic sw);
        cmd_valid = 1'b1; cmd_rows = rows; swap_req = sw; w_valid = 1'b0;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    // Issue a command and drive the stream until shadow_full is seen; strobes go to obs_q.
    task automatic run_tile(input logic [3:0] rows, input logic [15:0] vpat, input int vlen, input logic sw);
        logic v;
        logic [7:0] b;
        obs_q.delete();
        ncyc = 0; consumed = 0; wready_cnt = 0; cmdrdy_cnt = 0; saw_full = 1'b0;
        send_cmd(rows, sw);
        for (int c = 0; c < 40; c++) begin
            v = (c < vlen) ? vpat[c] : 1'b1;
            b = 8'(consumed + 1);
            tick(v, {8{b}}, sw);
            ncyc++;
            if (obs_row_en != 8'h00) obs_q.push_back({obs_row_en, obs_wout});
            if (v && obs_wready) consumed++;
            if (obs_wready) wready_cnt++;
            if (obs_cmd_ready) cmdrdy_cnt++;
            if (obs_full) begin
                saw_full = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_swap();
        tick(1'b0, 64'h0, 1'b1);
        tick(1'b0, 64'h0, 1'b0);
        tick(1'b0, 64'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b0; cmd_valid = 1'b0; cmd_rows = 4'd0; w_valid = 1'b0; w_data = 64'h0; swap_req = 1'b0;
        #3;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_cmd_ready got=%b want=1", cmd_ready); end
        total++; if ({w_ready, load_weight, shadow_full, preload_row_en} !== 11'h0) begin
            bad++; $display("FAIL reset_outputs got=%b%b%b_%h want=0", w_ready, load_weight, shadow_full, preload_row_en);
        end
        #9 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_tile();
        int lc;
        push_exp(4'd8);
        run_tile(4'd8, 16'h0, 0, 1'b0);
        total++; if (saw_full !== 1'b1 || ncyc != 9) begin bad++; $display("FAIL full_latency got=%0d want=9", ncyc); end
        total++; if (consumed != 8) begin bad++; $display("FAIL full_consumed got=%0d want=8", consumed); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL full_strobe_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL full_row got=%h want=%h", o, e); end
        end
        lc = load_cnt;
        tick(1'b0, 64'h0, 1'b1);
        total++; if ({obs_full, obs_load} !== 2'b10) begin bad++; $display("FAIL full_ready got=%b%b want=10", obs_full, obs_load); end
        tick(1'b0, 64'h0, 1'b0);
        total++; if ({obs_full, obs_load} !== 2'b11) begin bad++; $display("FAIL full_swap got=%b%b want=11", obs_full, obs_load); end
        tick(1'b0, 64'h0, 1'b0);
        total++; if ({obs_cmd_ready, obs_load, obs_full} !== 3'b100) begin
            bad++; $display("FAIL full_idle got=%b%b%b want=100", obs_cmd_ready, obs_load, obs_full);
        end
        total++; if (load_cnt - lc != 1) begin bad++; $display("FAIL full_load_pulses got=%0d want=1", load_cnt - lc); end
    endtask

    task automatic test_partial();
        push_exp(4'd3);
        run_tile(4'd3, 16'h0, 0, 1'b0);
        total++; if (consumed != 3 || wready_cnt != 3) begin bad++; $display("FAIL partial_ready got=%0d/%0d want=3/3", consumed, wready_cnt); end
        total++; if (ncyc != 9) begin bad++; $display("FAIL partial_latency got=%0d want=9", ncyc); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL partial_strobe_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL partial_row got=%h want=%h", o, e); end
        end
        do_swap();
    endtask

    task automatic test_stalls();
`ifdef WEIGHT_SEQ_PERF_EN
        logic [15:0] st0, tl0;
        st0 = perf_stall_cycles; tl0 = perf_tiles;
`endif
        push_exp(4'd4);
        // valid sequence 1,0,0,1,1,0,1 (bit 0 first)
        run_tile(4'd4, 16'b1011001, 7, 1'b0);
        total++; if (consumed != 4) begin bad++; $display("FAIL stall_consumed got=%0d want=4", consumed); end
        total++; if (ncyc != 12) begin bad++; $display("FAIL stall_latency got=%0d want=12", ncyc); end
        total++; if (cmdrdy_cnt != 0) begin bad++; $display("FAIL stall_cmd_ready got=%0d want=0", cmdrdy_cnt); end
        total++; if (obs_q.size() != exp_q.size()) begin bad++; $display("FAIL stall_strobe_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL stall_row got=%h want=%h", o, e); end
        end
        do_swap();
`ifdef WEIGHT_SEQ_PERF_EN
        total++; if (perf_stall_cycles - st0 != 16'd3) begin bad++; $display("FAIL perf_stall got=%0d want=3", perf_stall_cycles - st0); end
        total++; if (perf_tiles - tl0 != 16'd1) begin bad++; $display("FAIL perf_tiles got=%0d want=1", perf_tiles - tl0); end
`endif
    endtask

    task automatic test_early_swap();
        int lc;
        lc = load_cnt;
        push_exp(4'd2);
        run_tile(4'd2, 16'h0, 0, 1'b1);
        total++; if (ncyc != 9) begin bad++; $display("FAIL early_latency got=%0d want=9", ncyc); end
        total++; if (load_cnt != lc) begin bad++; $display("FAIL early_premature_load got=%0d want=0", load_cnt - lc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL early_row got=%h want=%h", o, e); end
        end
        tick(1'b0, 64'h0, 1'b1);
        total++; if (obs_load !== 1'b1) begin bad++; $display("FAIL early_load got=%b want=1", obs_load); end
        tick(1'b0, 64'h0, 1'b0);
        total++; if ({obs_cmd_ready, obs_load} !== 2'b10) begin bad++; $display("FAIL early_idle got=%b%b want=10", obs_cmd_ready, obs_load); end
        total++; if (load_cnt - lc != 1) begin bad++; $display("FAIL early_pulses got=%0d want=1", load_cnt - lc); end
    endtask

    task automatic test_clamp_zero();
        push_exp(4'd0);
        run_tile(4'd0, 16'h0, 0, 1'b0);
        total++; if (wready_cnt != 0 || consumed != 0) begin bad++; $display("FAIL zero_wready got=%0d want=0", wready_cnt); end
        total++; if (ncyc != 9) begin bad++; $display("FAIL zero_latency got=%0d want=9", ncyc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL zero_row got=%h want=%h", o, e); end
        end
        do_swap();
        push_exp(4'd15);
        run_tile(4'd15, 16'h0, 0, 1'b0);
        total++; if (consumed != 8 || wready_cnt != 8) begin bad++; $display("FAIL clamp_consumed got=%0d want=8", consumed); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL clamp_row got=%h want=%h", o, e); end
        end
        do_swap();
    endtask

    task automatic test_reset_mid_preload();
        send_cmd(4'd8, 1'b0);
        tick(1'b1, {8{8'h01}}, 1'b0);
        tick(1'b1, {8{8'h02}}, 1'b0);
        w_valid = 1'b1; w_data = {8{8'h03}};
        rst = 1'b0;
        #1;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rstmid_cmd_ready got=%b want=1", cmd_ready); end
        total++; if ({w_ready, load_weight, shadow_full, preload_row_en, weight_out} !== 75'h0) begin
            bad++; $display("FAIL rstmid_outputs got=%b%b%b_%h_%h want=0", w_ready, load_weight, shadow_full, preload_row_en, weight_out);
        end
        w_valid = 1'b0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        push_exp(4'd8);
        run_tile(4'd8, 16'h0, 0, 1'b0);
        total++; if (consumed != 8 || ncyc != 9) begin bad++; $display("FAIL rstmid_retile got=%0d/%0d want=8/9", consumed, ncyc); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : 72'h0;
            total++; if (o !== e) begin bad++; $display("FAIL rstmid_row got=%h want=%h", o, e); end
        end
        do_swap();
    endtask

    initial begin
        test_reset();
        test_full_tile();
        test_partial();
        test_stalls();
        test_early_swap();
        test_clamp_zero();
        test_reset_mid_preload();
        total++; if (viol != 0) begin bad++; $display("FAIL strobe_overlap got=%0d want=0", viol); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
